// File: rtl/fxmul_seq.sv
// ---------------------------------------------------------------------------
// fxmul_seq
//
// Sequential signed fixed-point multiplier (shift-add, one bit per cycle).
// Operands and product are two's-complement Q(WIDTH-FRAC).FRAC values.
// The operation works on magnitudes. The full-precision magnitude product is
// rounded half-away-from-zero back to FRAC fractional bits. The saved sign is
// then applied, and an out-of-range result is clamped (SAT=1) or wrapped
// (SAT=0).
//
// Parameters:
//   WIDTH    operand / product width in bits (4..64)
//   FRAC     fractional bits in operands and product (0..WIDTH-1)
//   SAT      1 = clamp on overflow, 0 = keep low WIDTH bits
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        clock enable; when low, all state (including done) holds
//   start     request, sampled only in IDLE with en=1
//   a, b      signed operands, captured on the accepting edge
//   busy      high while in RUN or FINISH
//   done      one-cycle registered pulse; product/overflow valid
//   product   signed result, held until the next done
//   overflow  rounded result was out of range, held until the next done
// ---------------------------------------------------------------------------
module fxmul_seq #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             overflow
);

    localparam int AW = 2 * WIDTH;
    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [SW-1:0]    LAST_STEP = SW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    // Half an output LSB, expressed in accumulator units.
    // When FRAC is 0, there is nothing to round, so the bias is zero.
    localparam logic [AW-1:0] ROUND_BIAS =
        (FRAC > 0) ? (AW'(1) << ((FRAC > 0) ? (FRAC - 1) : 0)) : '0;

    logic [1:0]       state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mag_a_q, mag_a_d;
    logic [WIDTH-1:0] mag_b_q, mag_b_d;
    logic             sign_q, sign_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] product_q, product_d;
    logic             overflow_q, overflow_d;

    logic [AW-1:0]    addend;
    logic [AW-1:0]    rounded;
    logic [AW-1:0]    mag_m;
    logic             ovf_c;
    logic [WIDTH-1:0] wrapped_c;
    logic [WIDTH-1:0] result_c;

    // Result formatting for FINISH.
    // Round the magnitude, check it against the signed range, apply the sign,
    // then clamp or wrap.
    // A negative result may reach 2^(WIDTH-1) because the most-negative value
    // is representable.
    always_comb begin
        addend  = {{WIDTH{1'b0}}, mag_a_q} << step_q;
        rounded = acc_q + ROUND_BIAS;
        mag_m   = rounded >> FRAC;
        if (sign_q) begin
            ovf_c = (|mag_m[AW-1:WIDTH]) ||
                    (mag_m[WIDTH-1] && (|mag_m[WIDTH-2:0]));
        end else begin
            ovf_c = |mag_m[AW-1:WIDTH-1];
        end
        wrapped_c = sign_q ? -mag_m[WIDTH-1:0] : mag_m[WIDTH-1:0];
        if (ovf_c && (SAT != 0)) begin
            result_c = sign_q ? MIN_NEG : MAX_POS;
        end else begin
            result_c = wrapped_c;
        end
    end

    // Next-state logic.
    // With en low, every register keeps its value, and done stays high if it
    // was high.
    // Any enabled edge clears done, except the FINISH edge, which sets it.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        acc_d      = acc_q;
        mag_a_d    = mag_a_q;
        mag_b_d    = mag_b_q;
        sign_d     = sign_q;
        done_d     = done_q;
        product_d  = product_q;
        overflow_d = overflow_q;
        if (en) begin
            done_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
                        mag_a_d = a[WIDTH-1] ? -a : a;
                        mag_b_d = b[WIDTH-1] ? -b : b;
                        acc_d   = '0;
                        step_d  = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (mag_b_q[step_q]) begin
                        acc_d = acc_q + addend;
                    end
                    if (step_q == LAST_STEP) begin
                        step_d  = '0;
                        state_d = ST_FINISH;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
                ST_FINISH: begin
                    product_d  = result_c;
                    overflow_d = ovf_c;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            acc_q      <= '0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            sign_q     <= 1'b0;
            done_q     <= 1'b0;
            product_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            acc_q      <= acc_d;
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            sign_q     <= sign_d;
            done_q     <= done_d;
            product_q  <= product_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q == ST_RUN) || (state_q == ST_FINISH);
    assign done     = done_q;
    assign product  = product_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fxmul_seq.sv
// ---------------------------------------------------------------------------
// tb_fxmul_seq
//
// Self-checking bench for fxmul_seq with WIDTH=32 and FRAC=16.
// Two instances share all inputs: one saturating (SAT=1) and one wrapping
// (SAT=0).
// Expected results come from directed constants or from an arithmetic
// reference model. The model uses a full 64-bit signed multiply, rounds the
// magnitude, then range-checks it.
// ---------------------------------------------------------------------------
module tb_fxmul_seq;

    logic        clk;
    logic        rst;
    logic        en;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy1, done1, ov1;
    logic [31:0] prod1;
    logic        busy0, done0, ov0;
    logic [31:0] prod0;

    int tests_run    = 0;
    int tests_failed = 0;

    fxmul_seq #(.WIDTH(32), .FRAC(16), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .start(start), .a(a), .b(b),
        .busy(busy1), .done(done1), .product(prod1), .overflow(ov1)
    );

    fxmul_seq #(.WIDTH(32), .FRAC(16), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .en(en), .start(start), .a(a), .b(b),
        .busy(busy0), .done(done0), .product(prod0), .overflow(ov0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: exact product, round half-away-from-zero, range check.
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  input bit sat, output logic [31:0] mp,
                                  output logic mov);
        longint pa, pb, pr, mag, m, r;
        bit     neg;
        pa  = longint'($signed(ma));
        pb  = longint'($signed(mb));
        pr  = pa * pb;
        neg = ma[31] ^ mb[31];
        mag = (pr < 0) ? -pr : pr;
        m   = (mag + 64'sd32768) >>> 16;
        if (neg) mov = (m > 64'sd2147483648);
        else     mov = (m > 64'sd2147483647);
        r = neg ? -m : m;
        if (mov && sat) mp = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else            mp = r[31:0];
    endfunction

    // Random operand in one of several magnitude ranges, so that results
    // are not all overflows.
    function automatic logic [31:0] rand_op();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 2))
            0:       rand_op = x;
            1:       rand_op = $signed(x) >>> $urandom_range(8, 20);
            default: rand_op = $signed(x) >>> $urandom_range(20, 30);
        endcase
    endfunction

    // Issue one operation and count the edges from acceptance to done.
    // Call this task #1 after an edge while both DUTs are IDLE.
    // It returns #1 after the edge that raised done.
    // lat stays -1 on timeout.
    task automatic do_op(input logic [31:0] op_a, input logic [31:0] op_b,
                         output int lat);
        en    = 1'b1;
        start = 1'b1;
        a     = op_a;
        b     = op_b;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        lat   = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (done1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({busy1, done1, ov1, prod1} !== 35'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_sat: busy=%b done=%b ov=%b prod=%h, expected all zero",
                     busy1, done1, ov1, prod1);
        end
        tests_run++;
        if ({busy0, done0, ov0, prod0} !== 35'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_wrap: busy=%b done=%b ov=%b prod=%h, expected all zero",
                     busy0, done0, ov0, prod0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] va[8]  = '{32'h0001_8000, 32'hFFFE_8000, 32'h7FFF_0000, 32'h8000_0000,
                                32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        logic [31:0] vb[8]  = '{32'h0002_0000, 32'h0002_0000, 32'h0002_0000, 32'h8000_0000,
                                32'h0001_0000, 32'h0000_8000, 32'h0000_8000, 32'h0000_7FFF};
        logic [31:0] ps[8]  = '{32'h0003_0000, 32'hFFFD_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                                32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        logic [31:0] pw[8]  = '{32'h0003_0000, 32'hFFFD_0000, 32'hFFFE_0000, 32'h0000_0000,
                                32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        logic        ovx[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int lat;
        for (int i = 0; i < 8; i++) begin
            do_op(va[i], vb[i], lat);
            tests_run++;
            if (lat !== 33) begin
                tests_failed++;
                $display("[TB] FAIL directed%0d_latency: got %0d edges, expected 33", i, lat);
            end
            tests_run++;
            if ({prod1, ov1} !== {ps[i], ovx[i]}) begin
                tests_failed++;
                $display("[TB] FAIL directed%0d_sat: got %h ov=%b, expected %h ov=%b",
                         i, prod1, ov1, ps[i], ovx[i]);
            end
            tests_run++;
            if ({prod0, ov0, done0} !== {pw[i], ovx[i], 1'b1}) begin
                tests_failed++;
                $display("[TB] FAIL directed%0d_wrap: got %h ov=%b done=%b, expected %h ov=%b done=1",
                         i, prod0, ov0, done0, pw[i], ovx[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] ra, rb, e1, e0;
        logic        o1, o0;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            ra = rand_op();
            rb = rand_op();
            model(ra, rb, 1'b1, e1, o1);
            model(ra, rb, 1'b0, e0, o0);
            do_op(ra, rb, lat);
            tests_run++;
            if (lat !== 33) begin
                tests_failed++;
                $display("[TB] FAIL random%0d_latency: got %0d, expected 33", i, lat);
            end
            tests_run++;
            if ({prod1, ov1} !== {e1, o1}) begin
                tests_failed++;
                $display("[TB] FAIL random%0d_sat a=%h b=%h: got %h ov=%b, expected %h ov=%b",
                         i, ra, rb, prod1, ov1, e1, o1);
            end
            tests_run++;
            if ({prod0, ov0} !== {e0, o0}) begin
                tests_failed++;
                $display("[TB] FAIL random%0d_wrap a=%h b=%h: got %h ov=%b, expected %h ov=%b",
                         i, ra, rb, prod0, ov0, e0, o0);
            end
        end
    endtask

    // start is asserted in the done cycle and must be accepted immediately.
    task automatic test_done_cycle_start();
        logic [31:0] e1;
        logic        o1;
        int          lat;
        do_op(32'h0003_0000, 32'hFFFF_8000, lat);
        tests_run++;
        if (done1 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL donecycle_pre: done=%b, expected 1", done1);
        end
        model(32'h0000_4000, 32'h0005_0000, 1'b1, e1, o1);
        do_op(32'h0000_4000, 32'h0005_0000, lat);
        tests_run++;
        if (lat !== 33 || prod1 !== e1) begin
            tests_failed++;
            $display("[TB] FAIL donecycle_issue: got lat=%0d prod=%h, expected lat=33 prod=%h",
                     lat, prod1, e1);
        end
    endtask

    // start is held high the whole time and junk operands are driven while
    // busy. Results come out once every 34 edges.
    task automatic test_back_to_back();
        logic [31:0] opa[3], opb[3], e1;
        logic        o1;
        int          edge_n, k;
        for (int i = 0; i < 3; i++) begin
            opa[i] = rand_op();
            opb[i] = rand_op();
        end
        en = 1'b1; start = 1'b1; a = opa[0]; b = opb[0];
        @(posedge clk);
        #1;
        a = $urandom; b = $urandom;
        edge_n = 0;
        k      = 0;
        while (k < 3 && edge_n < 200) begin
            @(posedge clk);
            edge_n++;
            #1;
            if (done1) begin
                model(opa[k], opb[k], 1'b1, e1, o1);
                tests_run++;
                if (edge_n !== 33 + 34 * k || prod1 !== e1 || ov1 !== o1 || busy1 !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b%0d: edge=%0d prod=%h ov=%b busy=%b, expected edge=%0d prod=%h ov=%b busy=0",
                             k, edge_n, prod1, ov1, busy1, 33 + 34 * k, e1, o1);
                end
                k++;
                if (k < 3) begin
                    a = opa[k];
                    b = opb[k];
                end else begin
                    start = 1'b0;
                end
            end else begin
                a = $urandom;
                b = $urandom;
            end
        end
        start = 1'b0;
        tests_run++;
        if (k !== 3) begin
            tests_failed++;
            $display("[TB] FAIL b2b_count: got %0d results, expected 3", k);
        end
    endtask

    task automatic test_stall();
        logic [31:0] sa, sb, e1;
        logic        o1;
        int          edge_n;
        sa = 32'hFFF3_4000;
        sb = 32'h0002_C000;
        model(sa, sb, 1'b1, e1, o1);
        en = 1'b1; start = 1'b1; a = sa; b = sb;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom;
        edge_n = 0;
        repeat (10) begin @(posedge clk); edge_n++; #1; end
        en = 1'b0;
        repeat (5) begin @(posedge clk); edge_n++; #1; end
        tests_run++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_run: busy=%b done=%b, expected busy=1 done=0", busy1, done1);
        end
        en = 1'b1;
        while (!done1 && edge_n < 150) begin @(posedge clk); edge_n++; #1; end
        tests_run++;
        if (edge_n !== 38 || prod1 !== e1 || ov1 !== o1) begin
            tests_failed++;
            $display("[TB] FAIL stall_result: edge=%0d prod=%h ov=%b, expected edge=38 prod=%h ov=%b",
                     edge_n, prod1, ov1, e1, o1);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            tests_run++;
            if (done1 !== 1'b1 || prod1 !== e1) begin
                tests_failed++;
                $display("[TB] FAIL stall_done_hold%0d: done=%b prod=%h, expected done=1 prod=%h",
                         i, done1, prod1, e1);
            end
        end
        en = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (done1 !== 1'b0 || prod1 !== e1) begin
            tests_failed++;
            $display("[TB] FAIL stall_done_clear: done=%b prod=%h, expected done=0 prod=%h",
                     done1, prod1, e1);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e1;
        logic        o1;
        int          lat, pulses;
        en = 1'b1; start = 1'b1; a = 32'h0012_3456; b = 32'h0003_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        // Reset and start together: reset must win on both edges.
        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if ({busy1, done1, ov1, prod1} !== 35'd0 || {busy0, done0, ov0, prod0} !== 35'd0) begin
            tests_failed++;
            $display("[TB] FAIL resetmid_state: busy=%b done=%b ov=%b prod=%h wrapprod=%h, expected all zero",
                     busy1, done1, ov1, prod1, prod0);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (busy1 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL resetmid_rst_wins: busy=%b, expected 0", busy1);
        end
        rst = 1'b0; start = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done1 || done0) pulses++;
        end
        tests_run++;
        if (pulses !== 0) begin
            tests_failed++;
            $display("[TB] FAIL resetmid_no_done: got %0d done pulses, expected 0", pulses);
        end
        model(32'hFFFF_0000, 32'h0000_C000, 1'b1, e1, o1);
        do_op(32'hFFFF_0000, 32'h0000_C000, lat);
        tests_run++;
        if (lat !== 33 || prod1 !== e1 || ov1 !== o1) begin
            tests_failed++;
            $display("[TB] FAIL resetmid_restart: lat=%0d prod=%h ov=%b, expected lat=33 prod=%h ov=%b",
                     lat, prod1, ov1, e1, o1);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_directed();
        test_random();
        test_done_cycle_start();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
